// File: rtl/layer_compositor.sv
`default_nettype none
// ============================================================================
//  Module      : layer_compositor
//  Description : Priority compositor for NUM_LAYERS palette-indexed layers.
//                The highest-priority enabled, non-transparent layer wins.
//                Its index is resolved through a writable palette, with an
//                optional frame-synchronous blink substitution.
//                Two-stage registered pipeline, one pixel per clock.
//  Revision    : 1.0 - initial release
// ============================================================================
module layer_compositor #(
    parameter int NUM_LAYERS   = 5,
    parameter int IDX_W        = 3,
    parameter int RGB_W        = 4,
    parameter int BLINK_FRAMES = 16,
    localparam int WL_W        = $clog2(NUM_LAYERS + 1)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        pix_valid_in,
    input  logic [NUM_LAYERS*IDX_W-1:0] layer_idx,
    input  logic [NUM_LAYERS-1:0]       layer_en,
    input  logic                        frame_start,
    input  logic                        pal_we,
    input  logic [IDX_W-1:0]            pal_addr,
    input  logic [RGB_W-1:0]            pal_data,
    input  logic                        blink_en,
    input  logic [IDX_W-1:0]            blink_idx,
    output logic [RGB_W-1:0]            rgb_out,
    output logic                        pix_valid_out,
    output logic [WL_W-1:0]             win_layer
);

    localparam int PAL_N = 2 ** IDX_W;
    localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [CNT_W-1:0] C_CNT_MAX = CNT_W'(BLINK_FRAMES - 1);
    localparam logic [WL_W-1:0]  C_NO_WIN  = WL_W'(NUM_LAYERS);

    // Power-up palette; entries beyond the first eight default to black.
    function automatic logic [RGB_W-1:0] pal_default(input int i);
        logic [7:0] v;
        case (i)
            0:       v = 8'h0;
            1:       v = 8'h3;
            2:       v = 8'h1;
            3:       v = 8'h7;
            4:       v = 8'h4;
            5:       v = 8'hD;
            6:       v = 8'h6;
            7:       v = 8'hB;
            default: v = 8'h0;
        endcase
        return RGB_W'(v);
    endfunction

    logic [RGB_W-1:0] r_palette [PAL_N];

    logic             r_s1_valid;
    logic [IDX_W-1:0] r_s1_idx;
    logic [WL_W-1:0]  r_s1_win;

    logic [CNT_W-1:0] r_blink_cnt;
    logic             r_blink_phase;

    logic [IDX_W-1:0] w_win_idx;
    logic [WL_W-1:0]  w_win_layer;
    logic             w_blink_hit;
    logic [IDX_W-1:0] w_rd_addr;

    // Priority select: scan from lowest priority upward so layer 0 wins last.
    always_comb begin
        w_win_idx   = '0;
        w_win_layer = C_NO_WIN;
        for (int k = NUM_LAYERS - 1; k >= 0; k--) begin
            if (layer_en[k] && (layer_idx[k*IDX_W +: IDX_W] != '0)) begin
                w_win_idx   = layer_idx[k*IDX_W +: IDX_W];
                w_win_layer = WL_W'(k);
            end
        end
    end

    // Blink substitution redirects the lookup to palette entry 0.
    always_comb begin
        w_blink_hit = blink_en && r_blink_phase &&
                      (r_s1_idx == blink_idx) && (r_s1_idx != '0);
        w_rd_addr   = w_blink_hit ? '0 : r_s1_idx;
    end

    // Stage 1: register the winning layer and its index.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1_valid <= 1'b0;
            r_s1_idx   <= '0;
            r_s1_win   <= C_NO_WIN;
        end else begin
            r_s1_valid <= pix_valid_in;
            r_s1_idx   <= w_win_idx;
            r_s1_win   <= w_win_layer;
        end
    end

    // Stage 2: palette lookup with blanking when the stage-1 pixel is invalid.
    always_ff @(posedge clk) begin
        if (reset) begin
            rgb_out       <= '0;
            pix_valid_out <= 1'b0;
            win_layer     <= C_NO_WIN;
        end else begin
            pix_valid_out <= r_s1_valid;
            rgb_out       <= r_s1_valid ? r_palette[w_rd_addr] : '0;
            win_layer     <= r_s1_valid ? r_s1_win : C_NO_WIN;
        end
    end

    // Palette storage; a lookup in the write cycle sees the pre-write value.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < PAL_N; i++) begin
                r_palette[i] <= pal_default(i);
            end
        end else if (pal_we) begin
            r_palette[pal_addr] <= pal_data;
        end
    end

    // Blink timer: phase flips every BLINK_FRAMES frame_start pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_blink_cnt   <= '0;
            r_blink_phase <= 1'b0;
        end else if (frame_start) begin
            if (r_blink_cnt == C_CNT_MAX) begin
                r_blink_cnt   <= '0;
                r_blink_phase <= ~r_blink_phase;
            end else begin
                r_blink_cnt   <= r_blink_cnt + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire
